// File: rtl/chip8_mem_xfer.sv
// Multi-byte CHIP-8 memory instruction engine: FX55 store, FX65 load, FX33 BCD.
// Define CHIP8_I_INCREMENT_EN for COSMAC VIP semantics (I advances by X+1 after FX55/FX65).
module chip8_mem_xfer #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned XW     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [XW-1:0]     cmd_x,
    input  logic [ADDR_W-1:0] cmd_i,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [7:0]        mem_rdata,
    output logic [XW-1:0]     reg_idx,
    input  logic [7:0]        reg_rdata,
    output logic              reg_we,
    output logic [XW-1:0]     reg_widx,
    output logic [7:0]        reg_wdata,
    output logic              done,
    output logic              err,
    output logic              i_we,
    output logic [ADDR_W-1:0] i_out
);

    localparam logic [1:0] OpStore = 2'b00;
    localparam logic [1:0] OpLoad  = 2'b01;
    localparam logic [1:0] OpBcd   = 2'b10;
    localparam logic [1:0] OpIll   = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StStore,
        StLoad,
        StLoadTail,
        StBcdLatch,
        StBcdWr,
        StDone
    } state_e;

    state_e              state_q, state_d;
    logic [XW-1:0]       k_q, k_d;
    logic [XW-1:0]       x_q, x_d;
    logic [ADDR_W-1:0]   i_q, i_d;
    logic [1:0]          op_q, op_d;
    logic [7:0]          bcd_q, bcd_d;

    logic [ADDR_W-1:0]   addr_k;
    logic [7:0]          bcd_hund, bcd_tens, bcd_ones;

    // Address arithmetic wraps naturally at ADDR_W bits.
    assign addr_k   = i_q + ADDR_W'(k_q);
    assign bcd_hund = bcd_q / 8'd100;
    assign bcd_tens = (bcd_q / 8'd10) % 8'd10;
    assign bcd_ones = bcd_q % 8'd10;

    assign cmd_ready = (state_q == StIdle);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            k_q     <= '0;
            x_q     <= '0;
            i_q     <= '0;
            op_q    <= '0;
            bcd_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            x_q     <= x_d;
            i_q     <= i_d;
            op_q    <= op_d;
            bcd_q   <= bcd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        x_d     = x_q;
        i_d     = i_q;
        op_d    = op_q;
        bcd_d   = bcd_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    x_d  = cmd_x;
                    i_d  = cmd_i;
                    op_d = cmd_op;
                    k_d  = '0;
                    unique case (cmd_op)
                        OpStore: state_d = StStore;
                        OpLoad:  state_d = StLoad;
                        OpBcd:   state_d = StBcdLatch;
                        OpIll:   state_d = StDone;
                        default: state_d = StDone;
                    endcase
                end
            end
            StStore: begin
                if (k_q == x_q) state_d = StDone;
                else            k_d = k_q + XW'(1);
            end
            StLoad: begin
                if (k_q == x_q) state_d = StLoadTail;
                else            k_d = k_q + XW'(1);
            end
            StLoadTail: state_d = StDone;
            StBcdLatch: begin
                bcd_d   = reg_rdata;
                k_d     = '0;
                state_d = StBcdWr;
            end
            StBcdWr: begin
                if (k_q == XW'(2)) state_d = StDone;
                else               k_d = k_q + XW'(1);
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_raddr = '0;
        reg_idx   = '0;
        reg_we    = 1'b0;
        reg_widx  = '0;
        reg_wdata = '0;
        done      = 1'b0;
        err       = 1'b0;
        i_we      = 1'b0;
        i_out     = '0;
        unique case (state_q)
            StStore: begin
                reg_idx   = k_q;
                mem_we    = 1'b1;
                mem_addr  = addr_k;
                mem_wdata = reg_rdata;
            end
            StLoad: begin
                mem_raddr = addr_k;
                // Read data lags the address by one cycle, so write back the previous index.
                if (k_q != '0) begin
                    reg_we    = 1'b1;
                    reg_widx  = k_q - XW'(1);
                    reg_wdata = mem_rdata;
                end
            end
            StLoadTail: begin
                reg_we    = 1'b1;
                reg_widx  = x_q;
                reg_wdata = mem_rdata;
            end
            StBcdLatch: reg_idx = x_q;
            StBcdWr: begin
                mem_we   = 1'b1;
                mem_addr = addr_k;
                if (k_q == '0)          mem_wdata = bcd_hund;
                else if (k_q == XW'(1)) mem_wdata = bcd_tens;
                else                    mem_wdata = bcd_ones;
            end
            StDone: begin
                done = 1'b1;
                err  = (op_q == OpIll);
`ifdef CHIP8_I_INCREMENT_EN
                if (op_q == OpStore || op_q == OpLoad) begin
                    i_we  = 1'b1;
                    i_out = i_q + ADDR_W'(x_q) + ADDR_W'(1);
                end
`else
                i_we  = 1'b0;
                i_out = '0;
`endif
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_chip8_mem_xfer.sv
// Randomized self-checking bench for chip8_mem_xfer with a transaction-level reference model.
`timescale 1ns/1ps
module tb_chip8_mem_xfer;

    localparam int AW = 12;
    localparam int XW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [XW-1:0] cmd_x;
    logic [AW-1:0] cmd_i;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic [AW-1:0] mem_raddr;
    logic [7:0]    mem_rdata;
    logic [XW-1:0] reg_idx;
    logic [7:0]    reg_rdata;
    logic          reg_we;
    logic [XW-1:0] reg_widx;
    logic [7:0]    reg_wdata;
    logic          done;
    logic          err;
    logic          i_we;
    logic [AW-1:0] i_out;

    chip8_mem_xfer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_x     (cmd_x),
        .cmd_i     (cmd_i),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_raddr (mem_raddr),
        .mem_rdata (mem_rdata),
        .reg_idx   (reg_idx),
        .reg_rdata (reg_rdata),
        .reg_we    (reg_we),
        .reg_widx  (reg_widx),
        .reg_wdata (reg_wdata),
        .done      (done),
        .err       (err),
        .i_we      (i_we),
        .i_out     (i_out)
    );

    always #5 clk = ~clk;

    // Environment: MMU RAM and V-register file, plus a poke port for preloading.
    logic [7:0]    ram  [4096];
    logic [7:0]    vreg [16];
    int            mem_we_cnt = 0;
    int            reg_we_cnt = 0;
    logic          poke_mem, poke_reg;
    logic [AW-1:0] poke_addr;
    logic [7:0]    poke_data;

    assign reg_rdata = vreg[reg_idx];

    always @(posedge clk) begin
        mem_rdata <= ram[mem_raddr];
        if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
            mem_we_cnt    <= mem_we_cnt + 1;
        end
        if (reg_we) begin
            vreg[reg_widx] <= reg_wdata;
            reg_we_cnt     <= reg_we_cnt + 1;
        end
        if (poke_mem) ram[poke_addr] <= poke_data;
        if (poke_reg) vreg[poke_addr[3:0]] <= poke_data;
    end

    // Reference model state and expected per-command transaction schedule.
    typedef struct {
        int         cyc;
        logic [11:0] addr;
        logic [7:0]  data;
    } wr_t;

    logic [7:0]  m_ram [4096];
    logic [7:0]  m_v   [16];
    wr_t         mq[$];
    wr_t         rq[$];
    int          exp_done_cyc;
    bit          exp_err, exp_iwe;
    logic [11:0] exp_iout;

    bit          active;
    int          cyc;
    int          done_seen_cyc;
    bit          last_err, last_iwe;
    logic [11:0] last_iout;

    int nchecks = 0;
    int nerr    = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    task automatic model_cmd(input logic [1:0] op, input int x, input int i, output int lat);
        wr_t w;
        int  a, v;
        int  dig[3];
        mq.delete();
        rq.delete();
        exp_err  = (op == 2'b11);
        exp_iwe  = 1'b0;
        exp_iout = 12'((i + x + 1) % 4096);
        case (op)
            2'b00: begin
                for (int k = 0; k <= x; k++) begin
                    a = (i + k) % 4096;
                    w.cyc = k + 1; w.addr = 12'(a); w.data = m_v[k];
                    mq.push_back(w);
                    m_ram[a] = m_v[k];
                end
                lat = x + 2;
`ifdef CHIP8_I_INCREMENT_EN
                exp_iwe = 1'b1;
`endif
            end
            2'b01: begin
                for (int k = 0; k <= x; k++) begin
                    a = (i + k) % 4096;
                    w.cyc = k + 2; w.addr = 12'(k); w.data = m_ram[a];
                    rq.push_back(w);
                    m_v[k] = m_ram[a];
                end
                lat = x + 3;
`ifdef CHIP8_I_INCREMENT_EN
                exp_iwe = 1'b1;
`endif
            end
            2'b10: begin
                v = int'(m_v[x]);
                dig[0] = v / 100;
                dig[1] = (v / 10) % 10;
                dig[2] = v % 10;
                for (int k = 0; k < 3; k++) begin
                    a = (i + k) % 4096;
                    w.cyc = k + 2; w.addr = 12'(a); w.data = 8'(dig[k]);
                    mq.push_back(w);
                    m_ram[a] = 8'(dig[k]);
                end
                lat = 5;
            end
            default: lat = 1;
        endcase
        exp_done_cyc = lat;
    endtask

    task automatic compare_loop();
        bit em, er, ed;
        forever begin
            @(negedge clk);
            if (rst_n && !active) begin
                chk("idle_ready", 32'(cmd_ready), 32'(1));
                chk("idle_we", 32'({mem_we, reg_we}), 32'(0));
                chk("idle_done", 32'({done, i_we}), 32'(0));
            end else if (rst_n) begin
                cyc++;
                em = (mq.size() != 0) && (mq[0].cyc == cyc);
                er = (rq.size() != 0) && (rq[0].cyc == cyc);
                ed = (cyc == exp_done_cyc);
                chk("busy_ready", 32'(cmd_ready), 32'(0));
                chk("mem_we", 32'(mem_we), 32'(em));
                if (em && mem_we) begin
                    chk("mem_addr", 32'(mem_addr), 32'(mq[0].addr));
                    chk("mem_wdata", 32'(mem_wdata), 32'(mq[0].data));
                end
                if (em) void'(mq.pop_front());
                chk("reg_we", 32'(reg_we), 32'(er));
                if (er && reg_we) begin
                    chk("reg_widx", 32'(reg_widx), 32'(rq[0].addr));
                    chk("reg_wdata", 32'(reg_wdata), 32'(rq[0].data));
                end
                if (er) void'(rq.pop_front());
                chk("done", 32'(done), 32'(ed));
                if (ed) begin
                    chk("err", 32'(err), 32'(exp_err));
                    chk("i_we", 32'(i_we), 32'(exp_iwe));
                    if (exp_iwe) chk("i_out", 32'(i_out), 32'(exp_iout));
                    done_seen_cyc = cyc;
                    last_err  = err;
                    last_iwe  = i_we;
                    last_iout = i_out;
                    active    = 1'b0;
                end else begin
                    chk("i_we_idle", 32'(i_we), 32'(0));
                end
            end
        end
    endtask

    task automatic poke(input bit is_reg, input int a, input logic [7:0] d);
        @(negedge clk);
        poke_mem  = !is_reg;
        poke_reg  = is_reg;
        poke_addr = 12'(a);
        poke_data = d;
        if (is_reg) m_v[a % 16] = d;
        else        m_ram[a % 4096] = d;
    endtask

    task automatic poke_end();
        @(negedge clk);
        poke_mem = 1'b0;
        poke_reg = 1'b0;
    endtask

    task automatic run_cmd(input logic [1:0] op, input int x, input int i, input bit garbage);
        int lat;
        @(negedge clk);
        chk("accept_ready", 32'(cmd_ready), 32'(1));
        model_cmd(op, x, i, lat);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_x     = 4'(x);
        cmd_i     = 12'(i);
        @(posedge clk);
        active        = 1'b1;
        cyc           = 0;
        done_seen_cyc = -1;
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            if (garbage && c < lat) begin
                cmd_valid = 1'($urandom_range(0, 1));
                cmd_op    = 2'($urandom);
                cmd_x     = 4'($urandom);
                cmd_i     = 12'($urandom);
            end else begin
                cmd_valid = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic check_arrays(string name);
        int bad;
        bad = 0;
        for (int j = 0; j < 4096; j++) if (ram[j] !== m_ram[j]) bad++;
        for (int j = 0; j < 16; j++) if (vreg[j] !== m_v[j]) bad++;
        chk(name, 32'(bad), 32'(0));
    endtask

    task automatic check_all_zero(string tag);
        chk({tag, "_mem_outs"}, 32'({mem_we, mem_addr, mem_wdata}), 32'(0));
        chk({tag, "_mem_raddr"}, 32'(mem_raddr), 32'(0));
        chk({tag, "_reg_outs"}, 32'({reg_we, reg_widx, reg_wdata, reg_idx}), 32'(0));
        chk({tag, "_ctl_outs"}, 32'({done, err, i_we, i_out}), 32'(0));
    endtask

    initial begin
        int mb, rb, x, i, sel;
        logic [1:0] op;
        cmd_valid = 1'b0; cmd_op = '0; cmd_x = '0; cmd_i = '0;
        poke_mem = 1'b0; poke_reg = 1'b0; poke_addr = '0; poke_data = '0;
        active = 1'b0; cyc = 0; done_seen_cyc = -1;
        fork
            compare_loop();
        join_none

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_all_zero("reset");
        chk("reset_ready", 32'(cmd_ready), 32'(1));
        @(negedge clk);
        rst_n = 1'b1;

        for (int j = 0; j < 4096; j++) poke(1'b0, j, 8'($urandom));
        for (int j = 0; j < 16; j++) poke(1'b1, j, 8'($urandom));
        poke_end();
        check_arrays("preload");

        // STORE X=3, I=0x300
        poke(1'b1, 0, 8'd11); poke(1'b1, 1, 8'd22); poke(1'b1, 2, 8'd33); poke(1'b1, 3, 8'd44);
        poke_end();
        mb = mem_we_cnt;
        run_cmd(2'b00, 3, 12'h300, 1'b0);
        chk("store_ram300", 32'(ram[12'h300]), 32'(11));
        chk("store_ram303", 32'(ram[12'h303]), 32'(44));
        chk("store_we_cnt", 32'(mem_we_cnt - mb), 32'(4));
        chk("store_done_cyc", 32'(done_seen_cyc), 32'(5));
        check_arrays("store_arrays");

        // LOAD X=2, I=0x400
        poke(1'b0, 12'h400, 8'hAA); poke(1'b0, 12'h401, 8'hBB); poke(1'b0, 12'h402, 8'hCC);
        poke_end();
        rb = reg_we_cnt;
        run_cmd(2'b01, 2, 12'h400, 1'b0);
        chk("load_v0", 32'(vreg[0]), 32'h0AA);
        chk("load_v1", 32'(vreg[1]), 32'h0BB);
        chk("load_v2", 32'(vreg[2]), 32'h0CC);
        chk("load_we_cnt", 32'(reg_we_cnt - rb), 32'(3));
        chk("load_done_cyc", 32'(done_seen_cyc), 32'(5));
        check_arrays("load_arrays");

        // BCD of 255 and 7 at I=0x500
        poke(1'b1, 5, 8'd255);
        poke_end();
        run_cmd(2'b10, 5, 12'h500, 1'b0);
        chk("bcd255", 32'({ram[12'h500], ram[12'h501], ram[12'h502]}), 32'h020505);
        chk("bcd_done_cyc", 32'(done_seen_cyc), 32'(5));
        poke(1'b1, 5, 8'd7);
        poke_end();
        run_cmd(2'b10, 5, 12'h500, 1'b0);
        chk("bcd7", 32'({ram[12'h500], ram[12'h501], ram[12'h502]}), 32'h000007);
        check_arrays("bcd_arrays");

        // STORE X=1 across the top of memory
        poke(1'b1, 0, 8'h5A); poke(1'b1, 1, 8'hA5);
        poke_end();
        run_cmd(2'b00, 1, 12'hFFF, 1'b0);
        chk("wrap_fff", 32'(ram[12'hFFF]), 32'h5A);
        chk("wrap_000", 32'(ram[12'h000]), 32'hA5);
`ifdef CHIP8_I_INCREMENT_EN
        chk("wrap_i_we", 32'(last_iwe), 32'(1));
        chk("wrap_i_out", 32'(last_iout), 32'h001);
`else
        chk("wrap_i_we", 32'(last_iwe), 32'(0));
`endif

        // Illegal op
        mb = mem_we_cnt;
        rb = reg_we_cnt;
        run_cmd(2'b11, 7, 12'h123, 1'b0);
        chk("ill_done_cyc", 32'(done_seen_cyc), 32'(1));
        chk("ill_err", 32'(last_err), 32'(1));
        chk("ill_we_cnt", 32'((mem_we_cnt - mb) + (reg_we_cnt - rb)), 32'(0));
        check_arrays("ill_arrays");

        // Reset during cycle 2 of STORE X=15
        @(negedge clk);
        mq.delete();
        rq.delete();
        begin
            wr_t w;
            w.cyc = 1; w.addr = 12'h600; w.data = m_v[0];
            mq.push_back(w);
        end
        exp_done_cyc = 1000;
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_x = 4'd15; cmd_i = 12'h600;
        mb = mem_we_cnt;
        @(posedge clk);
        active = 1'b1;
        cyc    = 0;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        active = 1'b0;
        #1;
        check_all_zero("abort");
        m_ram[12'h600] = m_v[0];
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_ready", 32'(cmd_ready), 32'(1));
        chk("abort_we_cnt", 32'(mem_we_cnt - mb), 32'(1));
        check_arrays("abort_arrays");
        run_cmd(2'b01, 0, 12'h600, 1'b0);
        chk("post_abort_v0", 32'(vreg[0]), 32'(m_ram[12'h600]));
        check_arrays("post_abort_arrays");

        // Randomized commands with cmd_valid noise while busy
        for (int n = 0; n < 40; n++) begin
            sel = int'($urandom_range(0, 9));
            op  = (sel < 3) ? 2'b00 : (sel < 6) ? 2'b01 : (sel < 9) ? 2'b10 : 2'b11;
            x   = int'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) i = 4096 - int'($urandom_range(1, 8));
            else                           i = int'($urandom_range(0, 4095));
            run_cmd(op, x, i, 1'b1);
            check_arrays("rand_arrays");
        end

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule

// File: doc/chip8_mem_xfer.md
Name: chip8_mem_xfer

Overview:
- Memory-side initiator that executes CHIP-8 multi-byte memory instructions against the MMU's byte read/write port and the V-register file.
  - FX55: store V0..VX to RAM[I..I+X].
  - FX65: load V0..VX from RAM[I..I+X].
  - FX33: write the BCD of VX to RAM[I..I+2].
- Sits between the instruction decoder (command side) and the MMU/register file (data side).
- This block drives writes; the MMU services them.

Parameters:
- ADDR_W, 12, RAM byte-address width; all address arithmetic is modulo 2^ADDR_W.
- XW, 4, register index width (16 V registers).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  decoder presents a command.
- cmd_ready  out  1  block idle and able to accept a command; combinational, equals (state==IDLE).
- cmd_op  in  2  00=STORE (FX55), 01=LOAD (FX65), 10=BCD (FX33), 11=illegal.
- cmd_x  in  XW  register index X.
- cmd_i  in  ADDR_W  current I register value.
- mem_we  out  1  byte write strobe to MMU.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  8  write data.
- mem_raddr  out  ADDR_W  read address; MMU returns mem_rdata exactly one cycle later.
- mem_rdata  in  8  read data from MMU.
- reg_idx  out  XW  register-file read index; reg_rdata is combinational from it.
- reg_rdata  in  8  V[reg_idx].
- reg_we  out  1  register-file write strobe.
- reg_widx  out  XW  register write index.
- reg_wdata  out  8  register write data.
- done  out  1  one-cycle pulse; command complete.
- err  out  1  valid with done; 1 for illegal op.
- i_we  out  1  I-register update strobe (see Optional Feature).
- i_out  out  ADDR_W  new I value.

Behaviour:
- Reset: asynchronous, active-low.
  - State goes to IDLE.
  - All registered outputs go to 0: mem_we, mem_addr, mem_wdata, mem_raddr, reg_we, reg_widx, reg_wdata, done, err, i_we, i_out, reg_idx.
  - cmd_ready reads 1 once state is IDLE.
- Handshake: a command is accepted on the clk edge where cmd_valid && cmd_ready (accept = cycle 0).
  - cmd_op, cmd_x and cmd_i are latched at that edge.
  - cmd_ready is 0 from cycle 1 until the cycle after done.
- States: IDLE, STORE, LOAD, LOAD_TAIL, BCD_LATCH, BCD_WR, DONE.
- STORE, cycles 1..X+1, counter k=0..X:
  - reg_idx=k, mem_we=1, mem_addr=(I+k) mod 4096, mem_wdata=reg_rdata.
  - After k==X, go to DONE.
- LOAD, cycles 1..X+1:
  - mem_raddr=(I+k) mod 4096.
  - From cycle 2, reg_we=1, reg_widx=k-1, reg_wdata=mem_rdata.
  - After k==X, go to LOAD_TAIL (cycle X+2): final write reg_widx=X. Then go to DONE.
- BCD:
  - BCD_LATCH (cycle 1): latch V[X] into an internal byte.
  - BCD_WR (cycles 2..4) writes three bytes:
    - hundreds digit to I;
    - tens digit to I+1;
    - ones digit to I+2.
  - All addresses are modulo 4096. Then go to DONE.
- Illegal op: no memory or register activity; go directly to DONE with err=1.
- DONE (one cycle): done=1; err per op; then return to IDLE.
- Latency from accept to done:
  - STORE: cycle X+2.
  - LOAD: cycle X+3.
  - BCD: cycle 5.
  - Illegal: cycle 1.
- mem_we and reg_we are 0 in every cycle not listed above.
- No overlapping commands; cmd_valid is ignored while busy.
- Wrap-around: the address counter wraps 4095->0; no error is raised.
- Reset mid-operation: abort immediately. No done pulse. Bytes already written remain written.

Optional Feature:
- Macro: CHIP8_I_INCREMENT_EN.
- Defined: in the DONE cycle of STORE/LOAD, i_we=1 and i_out=(I+X+1) mod 4096. This is COSMAC VIP semantics.
- BCD and illegal ops: i_we stays 0.
- Undefined: i_we and i_out are tied 0; I is unchanged (modern semantics).

Test Plan:
- STORE, X=3, I=0x300, V0..V3=11,22,33,44:
  - RAM[0x300..0x303]=11,22,33,44.
  - mem_we high exactly 4 cycles.
  - done at cycle 5.
- LOAD, X=2, I=0x400, RAM=0xAA,0xBB,0xCC:
  - V0..V2=AA,BB,CC.
  - reg_we high cycles 2..4.
  - done at cycle 5.
- BCD, V5=255, I=0x500:
  - RAM[0x500..0x502]=2,5,5; done at cycle 5.
  - Repeat with V5=7: 0,0,7.
- Wrap, STORE X=1, I=0xFFF:
  - writes land at 0xFFF then 0x000.
  - With CHIP8_I_INCREMENT_EN: i_out=0x001, i_we=1 on done.
- rst_n low at cycle 2 of STORE X=15:
  - all outputs 0; only bytes from cycle 1 written; no done.
  - cmd_ready=1 after release; the next command is accepted normally.
- cmd_op=11: done=1 and err=1 at cycle 1; no mem_we or reg_we at any time.
